mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_if.sv | 19 +
 rtl/mem_stage_timeout_counter.sv | 34 +++
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions for the memory stage: FSM encoding, timeout default
// and the pipeline control bits carried through EX/MEM.
package mem_stage_pkg;

   typedef enum logic {
      IDLE,
      WAIT
   } mem_state_e;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic reg_write;
   } ctrl_t;

   // Read+write together is not a legal access, so it shares the error path.
   function automatic logic is_misaligned(input logic [63:0] addr, input ctrl_t c);
      return (addr[2:0] != 3'b000) || (c.mem_read && c.mem_write);
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_timeout_counter.sv
// Wait-cycle counter for the memory stage; expired_o flags the last permitted
// waiting cycle, so the abort edge is the one that would make the count TIMEOUT.
module mem_timeout_counter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CW'(TIMEOUT - 32'd1));
endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through in one cycle, or issues an
// aligned load/store on the data-memory bus and waits for ack or timeout.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ValidI,
   input  logic [63:0] ResultI,
   input  logic [63:0] WriteDataI,
   input  logic [4:0]  RegI,
   input  logic        MemReadI,
   input  logic        MemWriteI,
   input  logic        MemToRegI,
   input  logic        RegWriteI,
   output logic        StallO,
   mem_stage_if.master dmem,
   output logic [63:0] loadedData,
   output logic [63:0] Results,
   output logic [4:0]  Reg,
   output logic        MemToReg,
   output logic        RegWrite,
   output logic        ValidO,
   output logic        MemErr
);
   mem_state_e  state_q, state_d;
   logic        req_q, req_d;
   logic [63:0] addr_q, addr_d, wdata_q, wdata_d;
   ctrl_t       ctrl_q, ctrl_d, ctrl_in;
   logic [4:0]  dst_q, dst_d;
   logic [63:0] ld_q, ld_d, res_q, res_d;
   logic [4:0]  reg_q, reg_d;
   logic        m2r_q, m2r_d, rw_q, rw_d, valid_q, valid_d, err_q, err_d;
   logic        stall, cnt_clear, cnt_en, expired;

   assign ctrl_in = '{mem_read: MemReadI, mem_write: MemWriteI,
                      mem_to_reg: MemToRegI, reg_write: RegWriteI};

   mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (cnt_clear),
      .enable_i  (cnt_en),
      .expired_o (expired)
   );

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ctrl_d    = ctrl_q;
      dst_d     = dst_q;
      ld_d      = ld_q;
      res_d     = res_q;
      reg_d     = reg_q;
      m2r_d     = m2r_q;
      rw_d      = 1'b0;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      stall     = 1'b0;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (ValidI) begin
               if (!(MemReadI || MemWriteI)) begin
                  res_d   = ResultI;
                  reg_d   = RegI;
                  m2r_d   = MemToRegI;
                  rw_d    = RegWriteI;
                  valid_d = 1'b1;
               end else if (is_misaligned(ResultI, ctrl_in)) begin
                  res_d   = ResultI;
                  reg_d   = RegI;
                  m2r_d   = MemToRegI;
                  valid_d = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d   = WAIT;
                  req_d     = 1'b1;
                  addr_d    = ResultI;
                  wdata_d   = WriteDataI;
                  ctrl_d    = ctrl_in;
                  dst_d     = RegI;
                  cnt_clear = 1'b1;
                  stall     = 1'b1;
               end
            end
         end
         WAIT: begin
            // Ack is checked before expiry so a same-cycle ack completes normally.
            if (dmem.dmem_ack || expired) begin
               state_d          = IDLE;
               req_d            = 1'b0;
               ctrl_d.mem_write = 1'b0;
               res_d            = addr_q;
               reg_d            = dst_q;
               m2r_d            = ctrl_q.mem_to_reg;
               valid_d          = 1'b1;
               if (dmem.dmem_ack) begin
                  rw_d = ctrl_q.reg_write;
                  if (ctrl_q.mem_read) begin
                     ld_d = dmem.dmem_rdata;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               cnt_en = 1'b1;
            end
            stall = !dmem.dmem_ack;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ctrl_q  <= '0;
         dst_q   <= '0;
         ld_q    <= '0;
         res_q   <= '0;
         reg_q   <= '0;
         m2r_q   <= 1'b0;
         rw_q    <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ctrl_q  <= ctrl_d;
         dst_q   <= dst_d;
         ld_q    <= ld_d;
         res_q   <= res_d;
         reg_q   <= reg_d;
         m2r_q   <= m2r_d;
         rw_q    <= rw_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign StallO          = rst_n && stall;
   assign dmem.dmem_req   = req_q;
   assign dmem.dmem_we    = ctrl_q.mem_write;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;
   assign loadedData      = ld_q;
   assign Results         = res_q;
   assign Reg             = reg_q;
   assign MemToReg        = m2r_q;
   assign RegWrite        = rw_q;
   assign ValidO          = valid_q;
   assign MemErr          = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: tasks push expected writeback results, a
// negedge monitor pops them whenever ValidO is seen.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ValidI = 1'b0;
   logic [63:0] ResultI = '0;
   logic [63:0] WriteDataI = '0;
   logic [4:0]  RegI = '0;
   logic        MemReadI = 1'b0, MemWriteI = 1'b0, MemToRegI = 1'b0, RegWriteI = 1'b0;
   logic        StallO;
   logic [63:0] loadedData, Results;
   logic [4:0]  Reg;
   logic        MemToReg, RegWrite, ValidO, MemErr;

   mem_stage_if dmem();

   mem_stage #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ValidI     (ValidI),
      .ResultI    (ResultI),
      .WriteDataI (WriteDataI),
      .RegI       (RegI),
      .MemReadI   (MemReadI),
      .MemWriteI  (MemWriteI),
      .MemToRegI  (MemToRegI),
      .RegWriteI  (RegWriteI),
      .StallO     (StallO),
      .dmem       (dmem.master),
      .loadedData (loadedData),
      .Results    (Results),
      .Reg        (Reg),
      .MemToReg   (MemToReg),
      .RegWrite   (RegWrite),
      .ValidO     (ValidO),
      .MemErr     (MemErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  rg;
      logic        rw;
      logic        err;
      logic        chk_ld;
      logic [63:0] ld;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   bit          mon_en = 1'b0;
   logic [63:0] model_ld = '0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (ValidO === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_valid: got ValidO=1, expected no output");
            end else begin
               mon_e = sb.pop_front();
               if (Results !== mon_e.res || Reg !== mon_e.rg) begin
                  bad++;
                  $display("FAIL wb_fields: got Results=%h Reg=%0d, expected Results=%h Reg=%0d",
                           Results, Reg, mon_e.res, mon_e.rg);
               end
               total++;
               if (RegWrite !== mon_e.rw || MemErr !== mon_e.err) begin
                  bad++;
                  $display("FAIL wb_flags: got RegWrite=%b MemErr=%b, expected RegWrite=%b MemErr=%b",
                           RegWrite, MemErr, mon_e.rw, mon_e.err);
               end
               if (mon_e.chk_ld) begin
                  total++;
                  if (loadedData !== mon_e.ld) begin
                     bad++;
                     $display("FAIL wb_load: got loadedData=%h, expected %h", loadedData, mon_e.ld);
                  end
               end
            end
         end else begin
            total++;
            if (ValidO !== 1'b0 || RegWrite !== 1'b0 || MemErr !== 1'b0) begin
               bad++;
               $display("FAIL bubble: got ValidO=%b RegWrite=%b MemErr=%b, expected 0 0 0",
                        ValidO, RegWrite, MemErr);
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [63:0] r, input logic [63:0] wd,
                        input logic [4:0] rg, input logic mr, input logic mw,
                        input logic m2r, input logic rw);
      ValidI = v; ResultI = r; WriteDataI = wd; RegI = rg;
      MemReadI = mr; MemWriteI = mw; MemToRegI = m2r; RegWriteI = rw;
   endtask

   task automatic drive_idle();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push_exp(input logic [63:0] res, input logic [4:0] rg, input logic rw,
                           input logic err, input logic chk_ld, input logic [63:0] ld);
      exp_t e;
      e.res = res; e.rg = rg; e.rw = rw; e.err = err; e.chk_ld = chk_ld; e.ld = ld;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      dmem.dmem_ack = 1'b0;
      dmem.dmem_rdata = '0;
      drive(1'b1, 64'h100, 64'h55, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk); @(negedge clk); #1;
      total++;
      if (StallO !== 1'b0) begin
         bad++; $display("FAIL reset_stall: got StallO=%b, expected 0", StallO);
      end
      total++;
      if ({dmem.dmem_req, dmem.dmem_we, ValidO, RegWrite, MemToReg, MemErr} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got req=%b we=%b ValidO=%b RegWrite=%b MemToReg=%b MemErr=%b, expected all 0",
                  dmem.dmem_req, dmem.dmem_we, ValidO, RegWrite, MemToReg, MemErr);
      end
      total++;
      if (loadedData !== '0 || Results !== '0 || Reg !== '0 || dmem.dmem_addr !== '0 || dmem.dmem_wdata !== '0) begin
         bad++;
         $display("FAIL reset_data: got ld=%h res=%h reg=%0d addr=%h wdata=%h, expected all 0",
                  loadedData, Results, Reg, dmem.dmem_addr, dmem.dmem_wdata);
      end
      drive_idle();
      rst_n = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_alu();
      @(negedge clk);
      drive(1'b1, 64'h2A, 64'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      total++;
      if (StallO !== 1'b0) begin
         bad++; $display("FAIL alu_stall: got StallO=%b, expected 0", StallO);
      end
      push_exp(64'h2A, 5'd5, 1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      drive_idle();
      #1;
      total++;
      if (StallO !== 1'b0 || dmem.dmem_req !== 1'b0) begin
         bad++; $display("FAIL alu_after: got StallO=%b req=%b, expected 0 0", StallO, dmem.dmem_req);
      end
   endtask

   task automatic test_load();
      logic exp_st;
      @(negedge clk);
      drive(1'b1, 64'h100, 64'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      total++;
      if (StallO !== 1'b1) begin
         bad++; $display("FAIL load_accept_stall: got StallO=%b, expected 1", StallO);
      end
      push_exp(64'h100, 5'd9, 1'b1, 1'b0, 1'b1, 64'hDEADBEEF);
      model_ld = 64'hDEADBEEF;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 3) begin
            dmem.dmem_ack = 1'b1;
            dmem.dmem_rdata = 64'hDEADBEEF;
         end
         #1;
         exp_st = (k != 3);
         total++;
         if (dmem.dmem_req !== 1'b1 || dmem.dmem_addr !== 64'h100 || dmem.dmem_we !== 1'b0) begin
            bad++;
            $display("FAIL load_bus: got req=%b addr=%h we=%b, expected 1 100 0",
                     dmem.dmem_req, dmem.dmem_addr, dmem.dmem_we);
         end
         total++;
         if (StallO !== exp_st) begin
            bad++; $display("FAIL load_stall: got StallO=%b, expected %b", StallO, exp_st);
         end
      end
      @(negedge clk);
      dmem.dmem_ack = 1'b0;
      drive_idle();
      #1;
      total++;
      if (dmem.dmem_req !== 1'b0) begin
         bad++; $display("FAIL load_req_drop: got req=%b, expected 0", dmem.dmem_req);
      end
   endtask

   task automatic test_store();
      @(negedge clk);
      drive(1'b1, 64'h208, 64'h55, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      push_exp(64'h208, 5'd7, 1'b0, 1'b0, 1'b1, model_ld);
      @(negedge clk);
      dmem.dmem_ack = 1'b1;
      dmem.dmem_rdata = 64'hFFFF_0000_FFFF_0000;
      #1;
      total++;
      if (dmem.dmem_req !== 1'b1 || dmem.dmem_we !== 1'b1 || dmem.dmem_wdata !== 64'h55 ||
          dmem.dmem_addr !== 64'h208) begin
         bad++;
         $display("FAIL store_bus: got req=%b we=%b wdata=%h addr=%h, expected 1 1 55 208",
                  dmem.dmem_req, dmem.dmem_we, dmem.dmem_wdata, dmem.dmem_addr);
      end
      total++;
      if (StallO !== 1'b0) begin
         bad++; $display("FAIL store_ack_stall: got StallO=%b, expected 0", StallO);
      end
      @(negedge clk);
      dmem.dmem_ack = 1'b0;
      drive_idle();
      #1;
      total++;
      if (dmem.dmem_req !== 1'b0 || dmem.dmem_we !== 1'b0) begin
         bad++; $display("FAIL store_drop: got req=%b we=%b, expected 0 0", dmem.dmem_req, dmem.dmem_we);
      end
   endtask

   task automatic test_error(input logic [63:0] addr, input logic mr, input logic mw, input logic [4:0] rg);
      @(negedge clk);
      drive(1'b1, addr, 64'h77, rg, mr, mw, 1'b1, 1'b1);
      #1;
      total++;
      if (StallO !== 1'b0 || dmem.dmem_req !== 1'b0) begin
         bad++; $display("FAIL err_accept: got StallO=%b req=%b, expected 0 0", StallO, dmem.dmem_req);
      end
      push_exp(addr, rg, 1'b0, 1'b1, 1'b0, '0);
      @(negedge clk);
      drive_idle();
      #1;
      total++;
      if (dmem.dmem_req !== 1'b0) begin
         bad++; $display("FAIL err_no_req: got req=%b, expected 0", dmem.dmem_req);
      end
   endtask

   task automatic test_timeout();
      int n;
      @(negedge clk);
      drive(1'b1, 64'h300, 64'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      push_exp(64'h300, 5'd8, 1'b0, 1'b1, 1'b0, '0);
      @(negedge clk);
      drive_idle();
      #1;
      n = 0;
      while (dmem.dmem_req === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
         #1;
      end
      total++;
      if (n != 4) begin
         bad++; $display("FAIL timeout_cycles: got %0d WAIT cycles, expected 4", n);
      end
      total++;
      if (dmem.dmem_req !== 1'b0) begin
         bad++; $display("FAIL timeout_req: got req=%b, expected 0", dmem.dmem_req);
      end
   endtask

   task automatic test_ack_at_timeout();
      @(negedge clk);
      drive(1'b1, 64'h400, 64'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      push_exp(64'h400, 5'd10, 1'b1, 1'b0, 1'b1, 64'h1234);
      model_ld = 64'h1234;
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      dmem.dmem_ack = 1'b1;
      dmem.dmem_rdata = 64'h1234;
      #1;
      total++;
      if (StallO !== 1'b0 || dmem.dmem_req !== 1'b1) begin
         bad++; $display("FAIL late_ack: got StallO=%b req=%b, expected 0 1", StallO, dmem.dmem_req);
      end
      @(negedge clk);
      dmem.dmem_ack = 1'b0;
      #1;
      total++;
      if (dmem.dmem_req !== 1'b0) begin
         bad++; $display("FAIL late_ack_drop: got req=%b, expected 0", dmem.dmem_req);
      end
   endtask

   task automatic test_ack_in_idle();
      @(negedge clk);
      drive_idle();
      dmem.dmem_ack = 1'b1;
      dmem.dmem_rdata = 64'hBAD0_BAD0;
      #1;
      total++;
      if (StallO !== 1'b0) begin
         bad++; $display("FAIL idle_ack_stall: got StallO=%b, expected 0", StallO);
      end
      @(negedge clk);
      dmem.dmem_ack = 1'b0;
      #1;
      total++;
      if (dmem.dmem_req !== 1'b0 || loadedData !== model_ld) begin
         bad++;
         $display("FAIL idle_ack: got req=%b loadedData=%h, expected 0 %h", dmem.dmem_req, loadedData, model_ld);
      end
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      drive(1'b1, 64'h500, 64'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      drive_idle();
      #1;
      total++;
      if (dmem.dmem_req !== 1'b1) begin
         bad++; $display("FAIL rstw_req: got req=%b, expected 1", dmem.dmem_req);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if (StallO !== 1'b0) begin
         bad++; $display("FAIL rstw_stall: got StallO=%b, expected 0", StallO);
      end
      @(negedge clk);
      #1;
      model_ld = '0;
      total++;
      if (dmem.dmem_req !== 1'b0 || ValidO !== 1'b0 || loadedData !== '0) begin
         bad++;
         $display("FAIL rstw_after: got req=%b ValidO=%b ld=%h, expected 0 0 0",
                  dmem.dmem_req, ValidO, loadedData);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b1, 64'h1000 + 64'(i), 64'h0, 5'(20 + i), 1'b0, 1'b0, 1'b0, 1'(i % 2));
         #1;
         push_exp(64'h1000 + 64'(i), 5'(20 + i), 1'(i % 2), 1'b0, 1'b0, '0);
      end
      @(negedge clk);
      drive(1'b1, 64'h608, 64'h0, 5'd30, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      push_exp(64'h608, 5'd30, 1'b1, 1'b0, 1'b1, 64'hCAFE);
      model_ld = 64'hCAFE;
      @(negedge clk);
      dmem.dmem_ack = 1'b1;
      dmem.dmem_rdata = 64'hCAFE;
      #1;
      total++;
      if (dmem.dmem_addr !== 64'h608 || StallO !== 1'b0) begin
         bad++; $display("FAIL b2b_load: got addr=%h StallO=%b, expected 608 0", dmem.dmem_addr, StallO);
      end
      @(negedge clk);
      dmem.dmem_ack = 1'b0;
      drive_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_error(64'h103, 1'b1, 1'b0, 5'd4);
      test_error(64'h200, 1'b1, 1'b1, 5'd6);
      test_timeout();
      test_ack_at_timeout();
      test_ack_in_idle();
      test_reset_in_wait();
      test_back_to_back();
      @(negedge clk);
      @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL leftover: got %0d pending outputs, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
